// File: rtl/xnor_frame_checker.sv
// xnor_frame_checker
//   Groups a stream of per-bit equality results (from xnor_gate) into frames
//   of FRAME_LEN valid bits. For each completed frame it reports whether all
//   bits matched and how many bits mismatched. It also keeps saturating totals
//   of the frames checked and of the frames that matched.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   eq_bit         per-bit compare result (1 = equal)
//   bit_valid      eq_bit is sampled this cycle
//   start          first bit of a frame (honoured only with bit_valid)
//   busy           a frame is in progress
//   done           one-cycle pulse: frame result valid
//   frame_match    all bits of the last frame were equal (held)
//   err_count      mismatches in the last frame (held)
//   aborted        one-cycle pulse: partial frame discarded by a new start
//   frames_total   completed frames, saturating
//   frames_matched completed matching frames, saturating
module xnor_frame_checker #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned ERR_W     = 4,
    parameter int unsigned TOT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eq_bit,
    input  logic             bit_valid,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             frame_match,
    output logic [ERR_W-1:0] err_count,
    output logic             aborted,
    output logic [TOT_W-1:0] frames_total,
    output logic [TOT_W-1:0] frames_matched
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   acc_q, acc_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               match_q, match_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [TOT_W-1:0]   tot_q, tot_d;
    logic [TOT_W-1:0]   mat_q, mat_d;

    // Error total including the bit presented this cycle.
    logic [ERR_W-1:0]   acc_inc;
    logic               last_bit;

    assign acc_inc  = acc_q + ERR_W'(~eq_bit);
    assign last_bit = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        match_d   = match_q;
        err_d     = err_q;
        tot_d     = tot_q;
        mat_d     = mat_q;

        unique case (state_q)
            IDLE: begin
                if (bit_valid && start) begin
                    state_d = ACCUM;
                    cnt_d   = CNT_W'(1);
                    acc_d   = ERR_W'(~eq_bit);
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    if (start) begin
                        // A new start wins even over a completing bit.
                        aborted_d = 1'b1;
                        cnt_d     = CNT_W'(1);
                        acc_d     = ERR_W'(~eq_bit);
                    end else if (last_bit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                        done_d  = 1'b1;
                        err_d   = acc_inc;
                        match_d = (acc_inc == '0);
                        if (tot_q != '1) begin
                            tot_d = tot_q + TOT_W'(1);
                        end
                        if ((acc_inc == '0) && (mat_q != '1)) begin
                            mat_d = mat_q + TOT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        acc_d = acc_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= '0;
            tot_q     <= '0;
            mat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            match_q   <= match_d;
            err_q     <= err_d;
            tot_q     <= tot_d;
            mat_q     <= mat_d;
        end
    end

    assign busy           = (state_q == ACCUM);
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign frame_match    = match_q;
    assign err_count      = err_q;
    assign frames_total   = tot_q;
    assign frames_matched = mat_q;

endmodule

// File: tb/tb_xnor_frame_checker.sv
// Directed, table-driven bench for xnor_frame_checker (FRAME_LEN=8, ERR_W=4,
// TOT_W=8). Each table row holds the inputs for one clock edge and the
// outputs expected just after that edge.
module tb_xnor_frame_checker;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned ERR_W     = 4;
    localparam int unsigned TOT_W     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             eq_bit;
    logic             bit_valid;
    logic             start;
    logic             busy;
    logic             done;
    logic             frame_match;
    logic [ERR_W-1:0] err_count;
    logic             aborted;
    logic [TOT_W-1:0] frames_total;
    logic [TOT_W-1:0] frames_matched;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic s, v, e;
        logic busy, done, match;
        int   err;
        logic abt;
        int   tot, mat;
    } vec_t;

    vec_t vecs[$];

    xnor_frame_checker #(
        .FRAME_LEN(FRAME_LEN),
        .ERR_W    (ERR_W),
        .TOT_W    (TOT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .eq_bit        (eq_bit),
        .bit_valid     (bit_valid),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .frame_match   (frame_match),
        .err_count     (err_count),
        .aborted       (aborted),
        .frames_total  (frames_total),
        .frames_matched(frames_matched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic e,
                       input logic b, input logic d, input logic m,
                       input int err, input logic a, input int tot, input int mat);
        vec_t r;
        r.s = s; r.v = v; r.e = e;
        r.busy = b; r.done = d; r.match = m; r.err = err;
        r.abt = a; r.tot = tot; r.mat = mat;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic s, input logic v, input logic e);
        start     = s;
        bit_valid = v;
        eq_bit    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic b, input logic d, input logic m,
                           input int err, input logic a, input int tot, input int mat);
        chk({tag, ".busy"},    int'(busy), int'(b));
        chk({tag, ".done"},    int'(done), int'(d));
        chk({tag, ".match"},   int'(frame_match), int'(m));
        chk({tag, ".err"},     int'(err_count), err);
        chk({tag, ".aborted"}, int'(aborted), int'(a));
        chk({tag, ".total"},   int'(frames_total), tot);
        chk({tag, ".matched"}, int'(frames_matched), mat);
    endtask

    initial begin
        logic [7:0] pat;
        int unsigned k;

        // Frame 1: eight matching bits.
        for (int unsigned i = 0; i < 8; i++)
            add(i == 0, 1, 1, i != 7, i == 7, i == 7, 0, 0, (i == 7) ? 1 : 0, (i == 7) ? 1 : 0);

        // Idle: start without valid, then valid without start, both ignored.
        add(1, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 1);

        // Frame 2: bits 1,0,1,1,0,1,1,0 with 0..3 idle cycles between bits.
        // start is held high in the gaps; with bit_valid low it must be ignored.
        pat = 8'b0110_1101;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i > 0)
                for (int unsigned g = 0; g < i % 4; g++)
                    add(1, 0, 0, 1, 0, 1, 0, 0, 1, 1);
            add(i == 0, 1, pat[i], i != 7, i == 7, (i == 7) ? 0 : 1,
                (i == 7) ? 3 : 0, 0, (i == 7) ? 2 : 1, 1);
        end

        // Frame 3: five bits with errors, then start+bit aborts and restarts.
        add(1, 1, 0, 1, 0, 0, 3, 0, 2, 1);
        add(0, 1, 0, 1, 0, 0, 3, 0, 2, 1);
        add(0, 1, 1, 1, 0, 0, 3, 0, 2, 1);
        add(0, 1, 0, 1, 0, 0, 3, 0, 2, 1);
        add(0, 1, 1, 1, 0, 0, 3, 0, 2, 1);
        add(1, 1, 1, 1, 0, 0, 3, 1, 2, 1);
        for (int unsigned i = 1; i < 8; i++)
            add(0, 1, 1, i != 7, i == 7, i == 7, (i == 7) ? 0 : 3, 0, (i == 7) ? 3 : 2, (i == 7) ? 2 : 1);

        // Frame 4: start arrives with what would be the completing bit.
        for (int unsigned i = 0; i < 7; i++)
            add(i == 0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 1, 0, 1, 0, 0, 3, 2);
        add(1, 1, 1, 1, 0, 1, 0, 1, 3, 2);
        for (int unsigned i = 1; i < 8; i++)
            add(0, 1, 1, i != 7, i == 7, 1, 0, 0, (i == 7) ? 4 : 3, (i == 7) ? 3 : 2);

        // Reset with X-free inputs.
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; eq_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].v, vecs[i].e);
            chk_all($sformatf("row%0d", i), vecs[i].busy, vecs[i].done, vecs[i].match,
                    vecs[i].err, vecs[i].abt, vecs[i].tot, vecs[i].mat);
        end

        // Reset after four bits of a frame: partial frame vanishes silently.
        for (int unsigned i = 0; i < 4; i++) drive(i == 0, 1, 1);
        chk("midframe.busy", int'(busy), 1);
        rst = 1'b1;
        drive(0, 1, 1);
        chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Valid bits with no start for ten cycles stay ignored.
        for (int unsigned i = 0; i < 10; i++) begin
            drive(0, 1, i[0]);
            chk_all($sformatf("nostart%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end

        // 300 back-to-back frames; each start coincides with the previous done.
        k = 0;
        for (int unsigned f = 0; f < 300; f++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                drive(b == 0, 1, 1);
                chk($sformatf("b2b%0d.done%0d", f, b), int'(done), (b == 7) ? 1 : 0);
                if (b == 0) chk($sformatf("b2b%0d.busy", f), int'(busy), 1);
            end
            k++;
            chk($sformatf("b2b%0d.total", f), int'(frames_total), (k > 255) ? 255 : int'(k));
            chk($sformatf("b2b%0d.matched", f), int'(frames_matched), (k > 255) ? 255 : int'(k));
        end
        drive(0, 0, 0);
        chk_all("sat.final", 0, 0, 1, 0, 0, 255, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
